// File: rtl/uno_pkg.sv
// Shared types and constants for the uno PE sequencer: FSM states, op codes
// and the polynomial coefficient table (signed, 8 fractional bits).
package uno_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_POLY,
    S_LAST,
    S_DRAIN
  } state_t;

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_EXP = 2'b10;
  localparam logic [1:0] OP_LOG = 2'b11;

  // Truncated series: 1/(1+x), e^x and ln(1+x); indices past 3 are zero.
  function automatic logic signed [15:0] coeff_lookup(input logic [1:0] op,
                                                      input int unsigned idx);
    coeff_lookup = 16'sd0;
    case (op)
      OP_DIV: begin
        case (idx)
          0, 2:    coeff_lookup = 16'sd256;
          1, 3:    coeff_lookup = -16'sd256;
          default: coeff_lookup = 16'sd0;
        endcase
      end
      OP_EXP: begin
        case (idx)
          0, 1:    coeff_lookup = 16'sd256;
          2:       coeff_lookup = 16'sd128;
          3:       coeff_lookup = 16'sd43;
          default: coeff_lookup = 16'sd0;
        endcase
      end
      OP_LOG: begin
        case (idx)
          1:       coeff_lookup = 16'sd256;
          2:       coeff_lookup = -16'sd128;
          3:       coeff_lookup = 16'sd85;
          default: coeff_lookup = 16'sd0;
        endcase
      end
      default: coeff_lookup = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/uno_coeff_rom.sv
// Combinational coefficient lookup: (op, index) -> BW-bit two's complement.
module uno_coeff_rom
  import uno_pkg::*;
#(
  parameter int BW    = 12,
  parameter int IDX_W = 2
) (
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] idx,
  output logic [BW-1:0]    coeff
);

  logic signed [15:0] raw;

  always_comb begin
    raw   = coeff_lookup(op, 32'(idx));
    coeff = BW'(raw);
  end

endmodule

// File: rtl/uno_ctrl.sv
// Command sequencer for the uno PE: runs MAC bursts or Horner-style polynomial
// passes (div/exp/log), then drains one cycle to flag the PE result.
`ifndef MAC_BW
`define MAC_BW 12
`endif

module uno_ctrl
  import uno_pkg::*;
#(
  parameter int BW    = `MAC_BW,
  parameter int ORD   = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [1:0]       uno_op,
  output logic             uno_first,
  output logic             uno_last,
  output logic             uno_acc_en,
  output logic [BW-1:0]    uno_coeff,
  output logic             opnd_rd,
  output logic             busy,
  output logic             res_valid
);

  localparam int IDX_W = (ORD < 1) ? 1 : $clog2(ORD + 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic [BW-1:0]    rom_coeff;

  uno_coeff_rom #(
    .BW    (BW),
    .IDX_W (IDX_W)
  ) u_rom (
    .op    (op_q),
    .idx   (idx_q),
    .coeff (rom_coeff)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    first_d    = 1'b0;
    cmd_ready  = 1'b0;
    uno_op     = '0;
    uno_first  = 1'b0;
    uno_last   = 1'b0;
    uno_acc_en = 1'b0;
    uno_coeff  = '0;
    opnd_rd    = 1'b0;
    res_valid  = 1'b0;
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          first_d = 1'b1;
          if (cmd_op == OP_MAC) begin
            state_d = S_MAC;
            // A zero length still runs one term so the PE sees a defined result.
            cnt_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            idx_d   = '0;
          end else begin
            state_d = S_POLY;
            cnt_d   = '0;
            idx_d   = IDX_W'(ORD);
          end
        end
      end
      S_MAC: begin
        uno_op     = op_q;
        opnd_rd    = 1'b1;
        uno_acc_en = !first_q;
        if (cnt_q <= LEN_W'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      S_POLY: begin
        uno_op    = op_q;
        uno_first = first_q;
        uno_coeff = rom_coeff;
        if (idx_q == '0) begin
          state_d = S_LAST;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_LAST: begin
        uno_op   = op_q;
        uno_last = 1'b1;
        state_d  = S_DRAIN;
      end
      S_DRAIN: begin
        uno_op    = op_q;
        res_valid = 1'b1;
        state_d   = S_IDLE;
        op_d      = '0;
      end
      default: begin
        state_d = S_IDLE;
        op_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uno_ctrl.sv
// Directed bench for uno_ctrl: cycle-by-cycle output checks per command type.
module tb_uno_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_len;
  logic [1:0]  uno_op;
  logic        uno_first;
  logic        uno_last;
  logic        uno_acc_en;
  logic [11:0] uno_coeff;
  logic        opnd_rd;
  logic        busy;
  logic        res_valid;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int rv_cnt   = 0;

  uno_ctrl #(
    .BW    (12),
    .ORD   (3),
    .LEN_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .uno_op     (uno_op),
    .uno_first  (uno_first),
    .uno_last   (uno_last),
    .uno_acc_en (uno_acc_en),
    .uno_coeff  (uno_coeff),
    .opnd_rd    (opnd_rd),
    .busy       (busy),
    .res_valid  (res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) acc_cnt++;
    if (!rst && res_valid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected coefficients (8 fractional bits, 12-bit two's complement).
  function automatic logic [11:0] ref_coeff(input int op, input int k);
    logic [11:0] c;
    c = 12'h000;
    case (op * 4 + k)
      4:  c = 12'h100;
      5:  c = 12'hF00;
      6:  c = 12'h100;
      7:  c = 12'hF00;
      8:  c = 12'h100;
      9:  c = 12'h100;
      10: c = 12'h080;
      11: c = 12'h02B;
      12: c = 12'h000;
      13: c = 12'h100;
      14: c = 12'hF80;
      15: c = 12'h055;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  task automatic expect_outs(input string tag, input logic rdy, input logic [1:0] op,
                             input logic fst, input logic lst, input logic acc,
                             input logic [11:0] coef, input logic rd, input logic bsy,
                             input logic rv);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy));
    check({tag, ".uno_op"}, 32'(uno_op), 32'(op));
    check({tag, ".uno_first"}, 32'(uno_first), 32'(fst));
    check({tag, ".uno_last"}, 32'(uno_last), 32'(lst));
    check({tag, ".uno_acc_en"}, 32'(uno_acc_en), 32'(acc));
    check({tag, ".uno_coeff"}, 32'(uno_coeff), 32'(coef));
    check({tag, ".opnd_rd"}, 32'(opnd_rd), 32'(rd));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".res_valid"}, 32'(res_valid), 32'(rv));
  endtask

  task automatic expect_idle(input string tag);
    expect_outs(tag, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // Starts in the first cycle after acceptance; ends in the following IDLE cycle.
  task automatic run_mac(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      expect_outs($sformatf("%s.mac%0d", tag, i), 1'b0, 2'd0, 1'b0, 1'b0, (i != 0),
                  12'h000, 1'b1, 1'b1, 1'b0);
      step();
    end
    expect_outs({tag, ".drain"}, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
    step();
    expect_idle({tag, ".idle"});
    $display("txn %s: MAC %0d terms done", tag, n);
  endtask

  task automatic run_poly(input string tag, input int op);
    for (int k = 3; k >= 0; k--) begin
      expect_outs($sformatf("%s.poly%0d", tag, k), 1'b0, 2'(op), (k == 3), 1'b0, 1'b0,
                  ref_coeff(op, k), 1'b0, 1'b1, 1'b0);
      step();
    end
    expect_outs({tag, ".last"}, 1'b0, 2'(op), 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    step();
    expect_outs({tag, ".drain"}, 1'b0, 2'(op), 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
    step();
    expect_idle({tag, ".idle"});
    $display("txn %s: poly op %0d done", tag, op);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_len   = 8'd0;
    step();
    step();
    rst = 1'b0;
    step();
    expect_idle("reset");
    $display("txn reset: released");

    // MAC, 4 terms
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 8'd4;
    step();
    cmd_valid = 1'b0;
    run_mac("mac4", 4);

    // exp polynomial
    cmd_valid = 1'b1; cmd_op = 2'd2;
    step();
    cmd_valid = 1'b0;
    run_poly("exp", 2);

    // zero-length MAC behaves as a single term
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 8'd0;
    step();
    cmd_valid = 1'b0;
    run_mac("mac0", 1);

    // log aborted by reset, div queued behind it
    cmd_valid = 1'b1; cmd_op = 2'd3;
    step();
    cmd_valid = 1'b0;
    expect_outs("abort.t1", 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, ref_coeff(3, 3), 1'b0, 1'b1, 1'b0);
    step();
    expect_outs("abort.t2", 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, ref_coeff(3, 2), 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
    step();
    rst = 1'b0;
    expect_idle("abort.t4");
    $display("txn abort: log aborted by reset");
    step();
    cmd_valid = 1'b0;
    run_poly("div", 1);

    // div then MAC held on cmd_valid back to back
    cmd_valid = 1'b1; cmd_op = 2'd1;
    step();
    cmd_op = 2'd0; cmd_len = 8'd2;
    run_poly("qdiv", 1);
    step();
    cmd_valid = 1'b0;
    run_mac("qmac", 2);
    step();
    step();
    expect_idle("post");

    check("accept_count", 32'(acc_cnt), 32'd7);
    check("res_valid_count", 32'(rv_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
